glitch_free_clk_div: RTL and testbench
======================================

# glitch_free_clk_div

Single-clock, glitch-free programmable clock divider with run-time ratio switching and a clean stop mode. This is the parametrised successor to the two-input glitch-free clock mux. It does not select between asynchronous sources; it derives a divided clock (`clk_out`) and a matching enable pulse from one master clock. A new ratio, or a stop, takes effect only on a period boundary, so no runt high or low phase is ever produced. It sits in the clocking block, feeding slow-domain logic and clock-enable consumers.

## Interface
- `DIV_W`, 8: width of divide ratios; legal run ratios are 2 .. 2^DIV_W-1.
- `RESET_DIV`, 2: ratio loaded at reset; must satisfy 2 <= `RESET_DIV` < 2^DIV_W.
- `clk`, in, 1: master clock; all logic on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `sw_req`, in, 1: switch request valid.
- `sw_div`, in, DIV_W: requested ratio; 0 = stop; 1 = illegal.
- `sw_rdy`, out, 1: request can be accepted (= not busy).
- `sw_ack`, out, 1: one-cycle pulse when the requested setting becomes active.
- `sw_err`, out, 1: one-cycle pulse, cycle after an illegal request (`sw_div`==1).
- `clk_out`, out, 1: registered divided clock.
- `clk_en`, out, 1: registered one-cycle pulse coincident with each rising edge of `clk_out`.
- `cur_div`, out, DIV_W: active ratio; 0 while stopped.

## Operation
- Phase counter `p` runs 0 .. N-1, where N = `cur_div`. Let hi = N>>1.
- `clk_out` = (p < hi): high for floor(N/2) cycles, low for ceil(N/2) cycles.
- `clk_en` = (p == 0) while running.
- States:
  - RUN: free-running, `sw_rdy`=1.
  - PEND: request accepted, waiting for a boundary, `sw_rdy`=0.
  - STOP: `clk_out`=0, `clk_en`=0, `sw_rdy`=1.
- Acceptance: `sw_req` & `sw_rdy` sampled at an edge.
  - `sw_div`==1: rejected. `sw_err`=1 for the following cycle; state, `cur_div` and `sw_rdy` are unchanged.
  - RUN with `sw_div` >= 2 or 0: go to PEND and latch `sw_div`.
- Boundary: the first edge after the acceptance edge at which p == N-1. The acceptance edge itself never switches.
  - New ratio >= 2: p <= 0, `cur_div` <= new ratio, `clk_out` <= 1, state RUN.
  - New ratio 0: `cur_div` <= 0, `clk_out` stays 0, state STOP.
  - In both cases `sw_ack`=1 for exactly the first cycle of the new setting.
- STOP with ratio >= 2: applied at the acceptance edge. p=0, `clk_out`=1, `clk_en`=1 and `sw_ack`=1 in the following cycle.
- STOP with ratio 0: `sw_ack` next cycle, nothing else changes.
- A request equal to `cur_div` still goes through PEND and the boundary. Phase is unaffected.
- `sw_req` while `sw_rdy`=0: ignored. No err, no ack, not queued.
- Width rules:
  - p and `cur_div` are DIV_W bits wide; hi = `cur_div`>>1, no extra bit needed.
  - Compare p == `cur_div`-1 in DIV_W bits; never evaluated while `cur_div`==0.

## Timing
- Reset (`rst_n`=0 at an edge), from any state: state RUN, `cur_div`=`RESET_DIV`, p=`RESET_DIV`-1, `clk_out`=0, `clk_en`=0, `sw_ack`=0, `sw_err`=0, `sw_rdy`=1.
- A pending request is dropped on reset and never acked.
- First edge after reset release: p=0, `clk_out`=1, `clk_en`=1.
- Switch latency from acceptance edge to `sw_ack` high: 1 .. old N edges in RUN; exactly 1 edge from STOP.
- Glitch-free guarantees, checked across every switch:
  - Every high phase lasts floor(N/2) cycles of a single ratio N.
  - Every low phase lasts ceil(N/2) cycles, or continues indefinitely in STOP.
- `clk_en` never fires twice within fewer than min(old, new) cycles.

## Structure
- Shared package `clk_div_pkg`:
  - state enum: `ST_RUN`, `ST_PEND`, `ST_STOP`.
  - constants: `DIV_STOP`=0, `DIV_ILLEGAL`=1.
- One natural sub-module, `div_phase_cnt`: a DIV_W wrap counter with synchronous load-to-zero and hold. It outputs p and the terminal flag (p == N-1).
- The top level holds the FSM, the latched request and the output registers.

## Test plan
- Reset with `RESET_DIV`=2, release `rst_n` -> `clk_out` goes 1,0,1,0 starting at the first edge; `clk_en` pulses every 2 cycles; `cur_div`=2.
- In RUN at div 2, request 5 -> `sw_rdy` low; `sw_ack` within 2 edges. Thereafter high 2, low 3; no phase shorter than 1 cycle across the switch.
- Request 0 at div 5 -> the current period completes, then `clk_out` is held 0, `cur_div`=0, ack. Next, request 3 -> ack 1 cycle later, `clk_out` runs high 1, low 2.
- Request 1 -> `sw_err` one cycle; `cur_div`, state and `sw_rdy` unchanged; no ack.
- Request 7 accepted, then assert `sw_req`=4 while `sw_rdy`=0 -> the second request is ignored; ratio 7 gives high 3, low 4.
- `rst_n` low for one cycle while in PEND -> reset values next cycle, no ack; the run resumes at `RESET_DIV`.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: state encoding and ratio code constants shared by the glitch-free clock divider
package clk_div_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_STOP} state_t;
    localparam int DIV_STOP    = 0;
    localparam int DIV_ILLEGAL = 1;
endpackage

// File: rtl/div_phase_cnt.sv
// div_phase_cnt: wrap counter 0..div-1 with synchronous clear-to-zero and hold
module div_phase_cnt #(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    input  logic             hold,
    output logic [DIV_W-1:0] p,
    output logic             term
);
    assign term = p == div - DIV_W'(1);
    always_ff @(posedge clk)
        p <= !rst_n ? DIV_W'(RESET_DIV - 1) : clr ? '0 : hold ? p : term ? '0 : p + DIV_W'(1);
endmodule

// File: rtl/glitch_free_clk_div.sv
// glitch_free_clk_div: programmable divided clock and enable with ratio/stop changes applied only on period boundaries
module glitch_free_clk_div
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_req,
    input  logic [DIV_W-1:0] sw_div,
    output logic             sw_rdy,
    output logic             sw_ack,
    output logic             sw_err,
    output logic             clk_out,
    output logic             clk_en,
    output logic [DIV_W-1:0] cur_div
);
    localparam logic [DIV_W-1:0] D_STOP = DIV_W'(DIV_STOP);
    localparam logic [DIV_W-1:0] D_ILL  = DIV_W'(DIV_ILLEGAL);
    state_t           state;
    logic [DIV_W-1:0] pend_div, p, p_nxt, hi;
    logic             term, acc, legal, clr;
    assign sw_rdy = state != ST_PEND;
    assign acc    = sw_req && sw_rdy;
    assign legal  = acc && sw_div != D_ILL;
    assign hi     = cur_div >> 1;
    assign p_nxt  = term ? '0 : p + DIV_W'(1);
    // restart the phase when a new running ratio takes over
    assign clr    = (state == ST_PEND && term && pend_div != D_STOP) ||
                    (state == ST_STOP && legal && sw_div != D_STOP);
    div_phase_cnt #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .div  (cur_div),
        .clr  (clr),
        .hold (state == ST_STOP),
        .p    (p),
        .term (term)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            cur_div  <= DIV_W'(RESET_DIV);
            pend_div <= '0;
            clk_out  <= 1'b0;
            clk_en   <= 1'b0;
            sw_ack   <= 1'b0;
            sw_err   <= 1'b0;
        end else begin
            sw_ack <= 1'b0;
            sw_err <= acc && sw_div == D_ILL;
            case (state)
                ST_RUN: begin
                    clk_out <= p_nxt < hi;
                    clk_en  <= p_nxt == '0;
                    if (legal) begin
                        state    <= ST_PEND;
                        pend_div <= sw_div;
                    end
                end
                ST_PEND: begin
                    if (term) begin
                        sw_ack  <= 1'b1;
                        cur_div <= pend_div;
                        state   <= pend_div == D_STOP ? ST_STOP : ST_RUN;
                        clk_out <= pend_div != D_STOP;
                        clk_en  <= pend_div != D_STOP;
                    end else begin
                        clk_out <= p_nxt < hi;
                        clk_en  <= p_nxt == '0;
                    end
                end
                default: begin
                    if (legal) begin
                        sw_ack <= 1'b1;
                        if (sw_div != D_STOP) begin
                            state   <= ST_RUN;
                            cur_div <= sw_div;
                            clk_out <= 1'b1;
                            clk_en  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_glitch_free_clk_div.sv
// tb_glitch_free_clk_div: scoreboarded cycle model plus per-scenario waveform and latency checks
module tb_glitch_free_clk_div;
    logic       clk = 1'b0, rst_n = 1'b0, sw_req = 1'b0;
    logic [7:0] sw_div = 8'd0;
    logic       sw_rdy, sw_ack, sw_err, clk_out, clk_en;
    logic [7:0] cur_div;
    int tests = 0, fails = 0;
    typedef struct packed {
        logic       out;
        logic       en;
        logic       ack;
        logic       err;
        logic       rdy;
        logic [7:0] div;
    } obs_t;
    obs_t sb[$];
    // reference model: 0 = run, 1 = pending, 2 = stopped
    int m_st = 0, m_div = 2, m_p = 1, m_pend = 0;

    always #5 clk = ~clk;

    glitch_free_clk_div #(.DIV_W(8), .RESET_DIV(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_req (sw_req),
        .sw_div (sw_div),
        .sw_rdy (sw_rdy),
        .sw_ack (sw_ack),
        .sw_err (sw_err),
        .clk_out(clk_out),
        .clk_en (clk_en),
        .cur_div(cur_div)
    );

    task automatic step(input logic r, input logic q, input int d);
        obs_t e, a, x;
        bit acc, ok;
        rst_n = r; sw_req = q; sw_div = 8'(d);
        e = '0;
        if (!r) begin
            m_st = 0; m_div = 2; m_p = 1;
            e.rdy = 1'b1; e.div = 8'd2;
        end else begin
            acc = q && m_st != 1;
            ok = acc && d != 1;
            e.err = acc && d == 1;
            if (m_st == 0) begin
                m_p = (m_p == m_div - 1) ? 0 : m_p + 1;
                if (ok) begin m_st = 1; m_pend = d; end
            end else if (m_st == 1) begin
                if (m_p == m_div - 1) begin
                    e.ack = 1'b1; m_p = 0; m_div = m_pend; m_st = (m_pend == 0) ? 2 : 0;
                end else m_p++;
            end else if (ok) begin
                e.ack = 1'b1;
                if (d != 0) begin m_st = 0; m_div = d; m_p = 0; end
            end
            e.out = m_st != 2 && m_p < m_div / 2;
            e.en  = m_st != 2 && m_p == 0;
            e.rdy = m_st != 1;
            e.div = 8'(m_div);
        end
        sb.push_back(e);
        @(posedge clk); #1;
        a = {clk_out, clk_en, sw_ack, sw_err, sw_rdy, cur_div};
        x = sb.pop_front();
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL scoreboard t=%0t out/en/ack/err/rdy/div got %b%b%b%b%b/%0d exp %b%b%b%b%b/%0d",
                     $time, a.out, a.en, a.ack, a.err, a.rdy, a.div, x.out, x.en, x.ack, x.err, x.rdy, x.div);
        end
    endtask

    task automatic wait_ack(input string name, input int max, input logic q, input int d);
        int lat = 0;
        for (int i = 1; i <= max + 2; i++) begin
            step(1'b1, q, d);
            if (sw_ack === 1'b1) begin lat = i; break; end
        end
        tests++;
        if (lat < 1 || lat > max) begin
            fails++;
            $display("FAIL %s ack latency got %0d need 1..%0d", name, lat, max);
        end
    endtask

    task automatic check_pattern(input string name, input int n, input logic [15:0] want);
        logic [15:0] pat = '0;
        pat[0] = clk_out;
        for (int i = 1; i < n; i++) begin
            step(1'b1, 1'b0, 0);
            pat = {pat[14:0], clk_out};
        end
        tests++;
        if (pat !== want) begin
            fails++;
            $display("FAIL %s clk_out pattern got %b exp %b", name, pat, want);
        end
    endtask

    task automatic test_reset();
        logic [5:0] po = '0, pe = '0;
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        tests++;
        if ({cur_div, clk_out, clk_en, sw_rdy, sw_ack, sw_err} !== {8'd2, 5'b00100}) begin
            fails++;
            $display("FAIL reset_state got div=%0d out=%b en=%b rdy=%b ack=%b err=%b", cur_div, clk_out, clk_en, sw_rdy, sw_ack, sw_err);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 0);
            po = {po[4:0], clk_out};
            pe = {pe[4:0], clk_en};
        end
        tests++;
        if (po !== 6'b101010) begin fails++; $display("FAIL reset_clk_out got %b exp 101010", po); end
        tests++;
        if (pe !== 6'b101010) begin fails++; $display("FAIL reset_clk_en got %b exp 101010", pe); end
    endtask

    task automatic test_switch_up();
        step(1'b1, 1'b1, 5);
        tests++;
        if (sw_rdy !== 1'b0) begin fails++; $display("FAIL switch_rdy got %b exp 0", sw_rdy); end
        wait_ack("switch_2to5", 2, 1'b0, 0);
        tests++;
        if (cur_div !== 8'd5) begin fails++; $display("FAIL switch_div got %0d exp 5", cur_div); end
        check_pattern("div5", 10, 16'b1100011000);
    endtask

    task automatic test_stop_start();
        int highs = 0;
        step(1'b1, 1'b1, 0);
        wait_ack("stop_from5", 5, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 0);
            highs += int'(clk_out) + int'(clk_en);
        end
        tests++;
        if (cur_div !== 8'd0 || clk_out !== 1'b0 || highs != 0) begin
            fails++;
            $display("FAIL stop_hold got div=%0d out=%b highs=%0d exp 0/0/0", cur_div, clk_out, highs);
        end
        step(1'b1, 1'b1, 3);
        tests++;
        if ({sw_ack, clk_out, clk_en, cur_div} !== {3'b111, 8'd3}) begin
            fails++;
            $display("FAIL start_from_stop got ack=%b out=%b en=%b div=%0d exp 1/1/1/3", sw_ack, clk_out, clk_en, cur_div);
        end
        check_pattern("div3", 6, 16'b100100);
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b1, 1);
        tests++;
        if ({sw_err, sw_ack, sw_rdy, cur_div} !== {3'b101, 8'd3}) begin
            fails++;
            $display("FAIL illegal got err=%b ack=%b rdy=%b div=%0d exp 1/0/1/3", sw_err, sw_ack, sw_rdy, cur_div);
        end
        step(1'b1, 1'b0, 0);
        tests++;
        if (sw_err !== 1'b0 || sw_ack !== 1'b0) begin
            fails++;
            $display("FAIL illegal_pulse got err=%b ack=%b exp 0/0", sw_err, sw_ack);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 7);
        wait_ack("busy_3to7", 3, 1'b1, 4);
        tests++;
        if (cur_div !== 8'd7) begin fails++; $display("FAIL busy_div got %0d exp 7", cur_div); end
        check_pattern("div7", 14, 16'b11100001110000);
    endtask

    task automatic test_reset_in_pend();
        int acks = 0;
        step(1'b1, 1'b1, 5);
        step(1'b0, 1'b0, 0);
        tests++;
        if ({cur_div, clk_out, clk_en, sw_rdy, sw_ack} !== {8'd2, 4'b0010}) begin
            fails++;
            $display("FAIL pend_reset got div=%0d out=%b en=%b rdy=%b ack=%b", cur_div, clk_out, clk_en, sw_rdy, sw_ack);
        end
        step(1'b1, 1'b0, 0);
        acks += int'(sw_ack);
        check_pattern("after_reset", 8, 16'b10101010);
        tests++;
        if (acks != 0 || cur_div !== 8'd2) begin
            fails++;
            $display("FAIL pend_dropped got acks=%0d div=%0d exp 0/2", acks, cur_div);
        end
    endtask

    initial begin
        test_reset();
        test_switch_up();
        test_stop_start();
        test_illegal();
        test_back_to_back();
        test_reset_in_pend();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
